lsu_mem_ctrl: RTL and testbench

- Load/store initiator between the single-cycle core and the word-addressed data memory.
- Accepts byte-addressed RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) and drives the memory's read-enable, write-enable, address and write-data pins.
- Extracts and sign/zero-extends load data.
- Performs read-modify-write for sub-word stores; flags misaligned or illegal accesses without touching memory.

---
 rtl/lsu_mem_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//   Load/store initiator between a single-cycle core and a word-addressed
//   data memory. It accepts byte-addressed RV32I loads/stores, extracts and
//   extends load data, performs read-modify-write for SB/SH, and reports
//   misaligned or illegal accesses without touching memory.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   req_valid       : request strobe, sampled only while req_ready=1
//   req_ready       : high only in IDLE
//   req_store       : 1=store, 0=load
//   req_funct3      : RV32I funct3 of the access
//   req_addr        : byte address (ADDR_W+2 bits)
//   req_wdata       : store data, LSB-justified
//   done            : one-cycle completion pulse
//   fault           : valid with done; 1=misaligned/illegal, no memory effect
//   load_data       : extended load result, held until the next good load
//   mem_read        : memory read enable
//   mem_write       : memory write enable (memory writes on the clk edge)
//   mem_addr        : word address of the latched request
//   mem_wdata       : word written to memory
//   mem_rdata       : combinational read data, valid with mem_read
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic              fault,
  output logic [31:0]       load_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned BA_W = ADDR_W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // funct3 size field
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [1:0]      state_q,     state_d;
  logic            store_q,     store_d;
  logic [2:0]      funct3_q,    funct3_d;
  logic [BA_W-1:0] addr_q,      addr_d;
  logic [31:0]     wdata_q,     wdata_d;
  logic            fault_q,     fault_d;
  logic [31:0]     load_data_q, load_data_d;
  logic [31:0]     merge_q,     merge_d;

  // Request decode on the input pins (only meaningful while accepting)
  logic req_legal_c;
  logic req_misaligned_c;
  logic req_fault_c;

  always_comb begin
    req_legal_c = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_legal_c = 1'b1;
      3'b100, 3'b101:         req_legal_c = !req_store;
      default:                req_legal_c = 1'b0;
    endcase
  end

  always_comb begin
    req_misaligned_c = 1'b0;
    if (req_funct3[1:0] == SZ_H) begin
      req_misaligned_c = req_addr[0];
    end else if (req_funct3[1:0] == SZ_W) begin
      req_misaligned_c = (req_addr[1:0] != 2'b00);
    end
  end

  assign req_fault_c = !req_legal_c || req_misaligned_c;

  // Load extraction from the addressed byte/halfword of the read word
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] ld_ext_c;

  always_comb begin
    ld_byte_c = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    ld_byte_c = mem_rdata[7:0];
      2'd1:    ld_byte_c = mem_rdata[15:8];
      2'd2:    ld_byte_c = mem_rdata[23:16];
      default: ld_byte_c = mem_rdata[31:24];
    endcase
    ld_half_c = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    ld_ext_c = mem_rdata;
    case (funct3_q)
      3'b000:  ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b100:  ld_ext_c = {24'd0, ld_byte_c};
      3'b001:  ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b101:  ld_ext_c = {16'd0, ld_half_c};
      default: ld_ext_c = mem_rdata;
    endcase
  end

  // Sub-word store merge: replace the addressed lane of the read word
  logic [31:0] merge_word_c;

  always_comb begin
    merge_word_c = mem_rdata;
    if (funct3_q[1:0] == SZ_B) begin
      case (addr_q[1:0])
        2'd0:    merge_word_c[7:0]   = wdata_q[7:0];
        2'd1:    merge_word_c[15:8]  = wdata_q[7:0];
        2'd2:    merge_word_c[23:16] = wdata_q[7:0];
        default: merge_word_c[31:24] = wdata_q[7:0];
      endcase
    end else if (funct3_q[1:0] == SZ_H) begin
      if (addr_q[1]) begin
        merge_word_c[31:16] = wdata_q[15:0];
      end else begin
        merge_word_c[15:0] = wdata_q[15:0];
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fault_d     = fault_q;
    load_data_d = load_data_q;
    merge_d     = merge_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          fault_d  = req_fault_c;
          if (req_fault_c) begin
            state_d = S_DONE;
          end else if (req_store && (req_funct3[1:0] == SZ_W)) begin
            state_d = S_WR;
          end else begin
            // loads and sub-word stores both need the current word first
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (store_q) begin
          merge_d = merge_word_c;
          state_d = S_WR;
        end else begin
          load_data_d = ld_ext_c;
          state_d     = S_DONE;
        end
      end
      S_WR: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      fault_q     <= 1'b0;
      load_data_q <= 32'd0;
      merge_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
      merge_q     <= merge_d;
    end
  end

  // Outputs decoded from registered state; enables gated by rst so a reset
  // edge landing in RD/WR never produces a memory access.
  assign req_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign fault     = (state_q == S_DONE) && fault_q;
  assign load_data = load_data_q;
  assign mem_read  = (state_q == S_RD) && !rst;
  assign mem_write = (state_q == S_WR) && !rst;
  assign mem_addr  = addr_q[BA_W-1:2];

  always_comb begin
    mem_wdata = 32'd0;
    if (state_q == S_WR) begin
      mem_wdata = (funct3_q[1:0] == SZ_W) ? wdata_q : merge_q;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//   Self-checking bench for lsu_mem_ctrl. A behavioural memory model and
//   load/store reference (plain shifts and masks over a word array) predict
//   latency, fault, load result and memory contents for every request.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned NWORDS = 64;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              done;
  logic              fault;
  logic [31:0]       load_data;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the DUT
  logic [31:0] mem [NWORDS];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  // Reference state
  logic [31:0] ref_mem [NWORDS];
  logic [31:0] ref_ld;

  int n_cmp;
  int n_fail;

  // Reference: applies one request to ref_mem/ref_ld, returns expectations
  task automatic model(input logic st, input logic [2:0] f3, input logic [7:0] a,
                       input logic [31:0] wd, output logic flt, output int lat,
                       output int erd, output int ewr);
    int sz;
    int sh;
    logic legal;
    logic mis;
    logic [31:0] w;
    logic [31:0] v;
    logic [31:0] mask;
    sz    = int'(f3[1:0]);
    legal = (f3 <= 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
    mis   = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    flt   = !legal || mis;
    w     = ref_mem[a[7:2]];
    sh    = 8 * int'(a[1:0]);
    if (flt) begin
      lat = 1; erd = 0; ewr = 0;
    end else if (!st) begin
      lat = 2; erd = 1; ewr = 0;
      v = w >> sh;
      if (sz == 0) begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 1) begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      end
      ref_ld = v;
    end else if (sz == 2) begin
      lat = 2; erd = 0; ewr = 1;
      ref_mem[a[7:2]] = wd;
    end else begin
      lat = 3; erd = 1; ewr = 1;
      mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
      ref_mem[a[7:2]] = (w & ~mask) | ((wd << sh) & mask);
    end
  endtask

  // Issue one request, watch the bus until done (bounded), check everything
  task automatic do_req(input string nm, input logic st, input logic [2:0] f3,
                        input logic [7:0] a, input logic [31:0] wd, input logic hold);
    logic eflt;
    logic got_flt;
    int elat, erd, ewr;
    int cyc, nrd, nwr, badaddr;
    logic seen;
    model(st, f3, a, wd, eflt, elat, erd, ewr);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready: got %b want 1", nm, req_ready);
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    cyc = 0; nrd = 0; nwr = 0; badaddr = 0; seen = 1'b0; got_flt = 1'b0;
    while (cyc < 8 && !seen) begin
      @(negedge clk);
      cyc++;
      if (!hold) req_valid = 1'b0;
      if (mem_read === 1'b1) nrd++;
      if (mem_write === 1'b1) begin
        nwr++;
        if (mem_addr !== a[7:2]) badaddr++;
      end
      if (done === 1'b1) begin
        seen = 1'b1; got_flt = fault;
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (!seen || cyc != elat) begin
      n_fail++; $display("FAIL %s latency: got %0d (seen=%b) want %0d", nm, cyc, seen, elat);
    end
    n_cmp++;
    if (got_flt !== eflt) begin
      n_fail++; $display("FAIL %s fault: got %b want %b", nm, got_flt, eflt);
    end
    n_cmp++;
    if (nrd != erd || nwr != ewr || badaddr != 0) begin
      n_fail++; $display("FAIL %s accesses: got rd=%0d wr=%0d badaddr=%0d want rd=%0d wr=%0d badaddr=0",
                         nm, nrd, nwr, badaddr, erd, ewr);
    end
    n_cmp++;
    if (load_data !== ref_ld) begin
      n_fail++; $display("FAIL %s load_data: got %h want %h", nm, load_data, ref_ld);
    end
    n_cmp++;
    if (mem[a[7:2]] !== ref_mem[a[7:2]]) begin
      n_fail++; $display("FAIL %s mem[%0d]: got %h want %h", nm, a[7:2], mem[a[7:2]], ref_mem[a[7:2]]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ref_ld = 32'd0;
    n_cmp++;
    if ({req_ready, done, fault, mem_read, mem_write} !== 5'b10000) begin
      n_fail++; $display("FAIL reset flags: got rdy/done/flt/rd/wr=%b want 10000",
                         {req_ready, done, fault, mem_read, mem_write});
    end
    n_cmp++;
    if (load_data !== 32'd0 || mem_addr !== '0 || mem_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset data: got ld=%h addr=%0d wdata=%h want 0", load_data, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_loads();
    do_req("lw_04",  1'b0, 3'b010, 8'h04, 32'd0, 1'b0);
    n_cmp++;
    if (load_data !== 32'h0000_0007) begin
      n_fail++; $display("FAIL lw_04 const: got %h want 00000007", load_data);
    end
    do_req("lb_08",  1'b0, 3'b000, 8'h08, 32'd0, 1'b0);
    n_cmp++;
    if (load_data !== 32'hFFFF_FFF7) begin
      n_fail++; $display("FAIL lb_08 const: got %h want fffffff7", load_data);
    end
    do_req("lbu_09", 1'b0, 3'b100, 8'h09, 32'd0, 1'b0);
    n_cmp++;
    if (load_data !== 32'h0000_00F0) begin
      n_fail++; $display("FAIL lbu_09 const: got %h want 000000f0", load_data);
    end
    do_req("lh_0a",  1'b0, 3'b001, 8'h0A, 32'd0, 1'b0);
    n_cmp++;
    if (load_data !== 32'hFFFF_8081) begin
      n_fail++; $display("FAIL lh_0a const: got %h want ffff8081", load_data);
    end
    do_req("lhu_0a", 1'b0, 3'b101, 8'h0A, 32'd0, 1'b0);
    n_cmp++;
    if (load_data !== 32'h0000_8081) begin
      n_fail++; $display("FAIL lhu_0a const: got %h want 00008081", load_data);
    end
  endtask

  task automatic test_stores();
    do_req("sb_09", 1'b1, 3'b000, 8'h09, 32'h0000_00AA, 1'b0);
    n_cmp++;
    if (mem[2] !== 32'h8081_AAF7) begin
      n_fail++; $display("FAIL sb_09 const: got %h want 8081aaf7", mem[2]);
    end
    do_req("sh_0a", 1'b1, 3'b001, 8'h0A, 32'h0000_1234, 1'b0);
    n_cmp++;
    if (mem[2] !== 32'h1234_AAF7) begin
      n_fail++; $display("FAIL sh_0a const: got %h want 1234aaf7", mem[2]);
    end
    do_req("sw_0c", 1'b1, 3'b010, 8'h0C, 32'hDEAD_BEEF, 1'b0);
    do_req("lw_0c", 1'b0, 3'b010, 8'h0C, 32'd0, 1'b0);
    n_cmp++;
    if (load_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL lw_0c const: got %h want deadbeef", load_data);
    end
  endtask

  task automatic test_faults();
    do_req("flt_lw_06",  1'b0, 3'b010, 8'h06, 32'd0, 1'b0);
    do_req("flt_sh_03",  1'b1, 3'b001, 8'h03, 32'h5555_5555, 1'b0);
    do_req("flt_st_100", 1'b1, 3'b100, 8'h10, 32'h6666_6666, 1'b0);
    do_req("flt_ld_111", 1'b0, 3'b111, 8'h10, 32'd0, 1'b0);
    do_req("flt_lhu_05", 1'b0, 3'b101, 8'h05, 32'd0, 1'b0);
  endtask

  task automatic test_hold_valid();
    // valid kept high through the whole access: only one access may occur
    do_req("hold_lw", 1'b0, 3'b010, 8'h08, 32'd0, 1'b1);
    do_req("hold_sb", 1'b1, 3'b000, 8'h13, 32'h0000_0042, 1'b1);
  endtask

  task automatic test_reset_in_wr();
    logic [31:0] old;
    old = mem[4];
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 8'h10;
    req_wdata = 32'h55AA_55AA;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (mem_write !== 1'b1) begin
      n_fail++; $display("FAIL rst_wr in_wr: got mem_write=%b want 1", mem_write);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL rst_wr done: got %b want 0", done);
    end
    @(negedge clk);
    ref_ld = 32'd0;
    n_cmp++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_wr ready: got rdy=%b done=%b want 1/0", req_ready, done);
    end
    n_cmp++;
    if (mem[4] !== old || load_data !== 32'd0) begin
      n_fail++; $display("FAIL rst_wr mem4: got %h ld=%h want %h ld=0", mem[4], load_data, old);
    end
    do_req("rst_wr_lw", 1'b0, 3'b010, 8'h10, 32'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] f3;
    for (int i = 0; i < 80; i++) begin
      // bias toward legal codes so most requests reach memory
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                       : 3'($urandom_range(0, 2));
      if (f3 <= 3'd2 && $urandom_range(0, 3) == 0) f3 = f3 | 3'b100;
      do_req("rand", 1'($urandom_range(0, 1)), f3, 8'($urandom_range(0, 255)),
             $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    ref_ld = 32'd0;
    for (int i = 0; i < int'(NWORDS); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[1] = 32'h0000_0007; ref_mem[1] = 32'h0000_0007;
    mem[2] = 32'h8081_F0F7; ref_mem[2] = 32'h8081_F0F7;

    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_hold_valid();
    test_reset_in_wr();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
